// File: rtl/pci_pkg.sv
// Shared PCI definitions for the config target.
// Command codes, sequencer states, abort limit.
package pci_pkg;

  localparam logic [3:0] CMD_CFG_READ  = 4'b1010;
  localparam logic [3:0] CMD_CFG_WRITE = 4'b1011;

  // Idle bus cycles tolerated in a data phase
  localparam int unsigned ABORT_CYCLES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_DATA,
    S_WR_COMMIT,
    S_TURN
  } state_e;

endpackage

// File: rtl/pci_cfg_target.sv
// PCI type-0 configuration target sequencer.
// Single data phase per access; bursts disconnect.
module pci_cfg_target
  import pci_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        idsel,
  input  logic [31:0] ad_in,
  input  logic [3:0]  cbe_n,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        ctl_oe,
  output logic        cfg_enable,
  output logic        cfg_iswrite,
  output logic [5:0]  cfg_offset,
  output logic [31:0] cfg_write_val,
  output logic [3:0]  cfg_byte_en,
  input  logic [31:0] cfg_read_val
);

  localparam logic [3:0] ABORT_LAST =
    4'(ABORT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        frame_prev_q;
  logic [3:0]  abort_q, abort_d;
  logic [31:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic        devsel_q, devsel_d;
  logic        trdy_q, trdy_d;
  logic        stop_q, stop_d;
  logic        ctl_oe_q, ctl_oe_d;
  logic        en_q, en_d;
  logic        isw_q, isw_d;
  logic [5:0]  off_q, off_d;
  logic [31:0] wval_q, wval_d;
  logic [3:0]  be_q, be_d;

  logic is_rd;
  logic is_wr;
  logic claim;
  logic master_idle;
  logic abort_hit;

  assign is_rd = (cbe_n == CMD_CFG_READ);
  assign is_wr = (cbe_n == CMD_CFG_WRITE);

  // Only the first FRAME# low cycle is an
  // address phase we may claim.
  assign claim = ~frame_n & frame_prev_q
               & idsel
               & (ad_in[1:0] == 2'b00)
               & (is_rd | is_wr);

  assign master_idle = frame_n & irdy_n;
  assign abort_hit   = master_idle
                     & (abort_q == ABORT_LAST);

  // Next state, abort counting and request capture
  always_comb begin
    state_d = state_q;
    abort_d = '0;
    off_d   = off_q;
    wval_d  = wval_q;
    be_d    = be_q;
    unique case (state_q)
      S_IDLE: begin
        if (claim) begin
          off_d   = ad_in[7:2];
          state_d = is_rd ? S_RD_REQ : S_WR_DATA;
        end
      end
      S_RD_REQ: state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (!irdy_n || abort_hit) begin
          state_d = S_TURN;
        end else if (master_idle) begin
          abort_d = abort_q + 4'd1;
        end
      end
      S_WR_DATA: begin
        if (!irdy_n) begin
          wval_d  = ad_in;
          be_d    = ~cbe_n;
          state_d = S_WR_COMMIT;
        end else if (abort_hit) begin
          state_d = S_TURN;
        end else if (master_idle) begin
          abort_d = abort_q + 4'd1;
        end
      end
      S_WR_COMMIT: state_d = S_TURN;
      S_TURN:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Registered outputs for the state being entered
  always_comb begin
    ad_out_d = ad_out_q;
    ad_oe_d  = 1'b0;
    devsel_d = 1'b1;
    trdy_d   = 1'b1;
    stop_d   = 1'b1;
    ctl_oe_d = 1'b0;
    en_d     = 1'b0;
    isw_d    = 1'b0;
    unique case (state_d)
      S_RD_REQ: begin
        devsel_d = 1'b0;
        ctl_oe_d = 1'b1;
        en_d     = 1'b1;
      end
      S_RD_DATA: begin
        if (state_q == S_RD_REQ) begin
          ad_out_d = cfg_read_val;
        end
        ad_oe_d  = 1'b1;
        devsel_d = 1'b0;
        trdy_d   = 1'b0;
        stop_d   = frame_n;
        ctl_oe_d = 1'b1;
      end
      S_WR_DATA: begin
        devsel_d = 1'b0;
        trdy_d   = 1'b0;
        stop_d   = frame_n;
        ctl_oe_d = 1'b1;
      end
      S_WR_COMMIT: begin
        ctl_oe_d = 1'b1;
        en_d     = |be_d;
        isw_d    = 1'b1;
      end
      // Reads drive the controls high once
      // before releasing them.
      S_TURN: ctl_oe_d = (state_q == S_RD_DATA);
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b1;
      abort_q      <= '0;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      devsel_q     <= 1'b1;
      trdy_q       <= 1'b1;
      stop_q       <= 1'b1;
      ctl_oe_q     <= 1'b0;
      en_q         <= 1'b0;
      isw_q        <= 1'b0;
      off_q        <= '0;
      wval_q       <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_n;
      abort_q      <= abort_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      devsel_q     <= devsel_d;
      trdy_q       <= trdy_d;
      stop_q       <= stop_d;
      ctl_oe_q     <= ctl_oe_d;
      en_q         <= en_d;
      isw_q        <= isw_d;
      off_q        <= off_d;
      wval_q       <= wval_d;
      be_q         <= be_d;
    end
  end

  assign ad_out        = ad_out_q;
  assign ad_oe         = ad_oe_q;
  assign devsel_n      = devsel_q;
  assign trdy_n        = trdy_q;
  assign stop_n        = stop_q;
  assign ctl_oe        = ctl_oe_q;
  assign cfg_enable    = en_q;
  assign cfg_iswrite   = isw_q;
  assign cfg_offset    = off_q;
  assign cfg_write_val = wval_q;
  assign cfg_byte_en   = be_q;

endmodule

// File: tb/tb_pci_cfg_target.sv
// Bench for pci_cfg_target: table vectors,
// corner sequences and random transactions.
module tb_pci_cfg_target;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_n = 1'b1;
  logic        irdy_n = 1'b1;
  logic        idsel = 1'b0;
  logic [31:0] ad_in = '0;
  logic [3:0]  cbe_n = 4'hF;
  logic [31:0] cfg_read_val = '0;
  logic [31:0] ad_out;
  logic        ad_oe, devsel_n, trdy_n, stop_n;
  logic        ctl_oe, cfg_enable, cfg_iswrite;
  logic [5:0]  cfg_offset;
  logic [31:0] cfg_write_val;
  logic [3:0]  cfg_byte_en;

  pci_cfg_target dut (
    .clk           (clk),
    .rst           (rst),
    .frame_n       (frame_n),
    .irdy_n        (irdy_n),
    .idsel         (idsel),
    .ad_in         (ad_in),
    .cbe_n         (cbe_n),
    .ad_out        (ad_out),
    .ad_oe         (ad_oe),
    .devsel_n      (devsel_n),
    .trdy_n        (trdy_n),
    .stop_n        (stop_n),
    .ctl_oe        (ctl_oe),
    .cfg_enable    (cfg_enable),
    .cfg_iswrite   (cfg_iswrite),
    .cfg_offset    (cfg_offset),
    .cfg_write_val (cfg_write_val),
    .cfg_byte_en   (cfg_byte_en),
    .cfg_read_val  (cfg_read_val)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] RD = 4'b1010;
  localparam logic [3:0] WR = 4'b1011;

  typedef struct {
    logic [3:0]  cmd;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  dbe_n;
    int          waits;
    logic        burst;
    logic        exp_claim;
    logic        exp_strobe;
    logic [31:0] exp_val;
    logic [3:0]  exp_be;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // mem: register file seen by the DUT
  // exp_mem: what the model says it holds
  logic [31:0] mem [64];
  logic [31:0] exp_mem [64];
  logic        en_prev = 1'b0;

  vec_t  tbl [13];
  string tnm [13];
  vec_t  rv;
  logic [95:0] rst_exp;
  logic  d16, d17;
  int    ab_str;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = {8{be[i]}};
    return (old & ~m) | (nw & m);
  endfunction

  function automatic vec_t mk(
    input logic [3:0]  cmd,
    input logic        sel,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  dbe_n,
    input int          waits,
    input logic        burst,
    input logic        claim,
    input logic        strobe,
    input logic [31:0] val,
    input logic [3:0]  be);
    vec_t v;
    v.cmd = cmd;       v.sel = sel;
    v.addr = addr;     v.wdata = wdata;
    v.dbe_n = dbe_n;   v.waits = waits;
    v.burst = burst;   v.exp_claim = claim;
    v.exp_strobe = strobe;
    v.exp_val = val;   v.exp_be = be;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // Clock edge plus the register file's reply
  task automatic tick();
    @(posedge clk);
    #1;
    chk("strobe_twice", {95'b0, en_prev & cfg_enable},
        96'b0);
    en_prev = cfg_enable;
    if (cfg_enable && !cfg_iswrite) begin
      cfg_read_val = mem[cfg_offset];
    end else begin
      if (cfg_enable)
        mem[cfg_offset] = merge(mem[cfg_offset],
                                cfg_write_val,
                                cfg_byte_en);
      cfg_read_val = $urandom;
    end
  endtask

  task automatic run_txn(input vec_t v,
                         input string nm);
    logic rd, done, unstable, dev_seen, dev_a1;
    logic turn_dev, turn_oe, stopv, exp_stop, isw;
    logic [5:0]  off;
    logic [31:0] wv, rdat, first_ad;
    logic [3:0]  be;
    int k, w, strobes, stb_k, trdy_k, xfer_k;
    int tail, limit, exp_x;
    rd = (v.cmd == RD);
    done = 0; unstable = 0; dev_seen = 0;
    dev_a1 = 1; turn_dev = 0; turn_oe = 0;
    stopv = 1; isw = 0; off = 0; wv = 0;
    rdat = 0; first_ad = 0; be = 0;
    strobes = 0; stb_k = -1; trdy_k = -1;
    xfer_k = -1; w = v.waits;
    tail = rd ? 2 : 3;
    limit = v.exp_claim ? 40 : 7;
    frame_n = 0; irdy_n = 1; idsel = v.sel;
    ad_in = v.addr; cbe_n = v.cmd;
    tick();
    k = 1;
    while (k < limit &&
           !(done && k == xfer_k + tail)) begin
      if (cfg_enable) begin
        strobes++; stb_k = k;
        isw = cfg_iswrite; off = cfg_offset;
        wv = cfg_write_val; be = cfg_byte_en;
      end
      if (!devsel_n) dev_seen = 1;
      if (k == 1) dev_a1 = devsel_n;
      if (done && k == xfer_k + 1) begin
        turn_dev = devsel_n;
        turn_oe  = ctl_oe;
      end
      if (!done && trdy_k >= 0) begin
        if (trdy_n || ad_out !== first_ad)
          unstable = 1;
      end
      if (!done && trdy_k < 0 && !trdy_n) begin
        trdy_k = k;
        first_ad = ad_out;
      end
      if (!done && v.exp_claim) begin
        idsel = 0;
        ad_in = rd ? $urandom : v.wdata;
        cbe_n = rd ? 4'h0 : v.dbe_n;
        irdy_n = (w > 0);
        frame_n = v.burst ? 1'b0 : (w == 0);
        if (!irdy_n && !trdy_n) begin
          done = 1; xfer_k = k;
          rdat = ad_out; stopv = stop_n;
        end
        if (w > 0) w--;
      end else begin
        frame_n = 1; irdy_n = 1; idsel = 0;
        ad_in = $urandom; cbe_n = 4'hF;
      end
      tick();
      k++;
    end
    if (v.exp_claim) begin
      chk({nm, "_done"}, done, 1);
      chk({nm, "_devsel_a1"}, dev_a1, 0);
      chk({nm, "_strobes"}, strobes,
          v.exp_strobe);
      if (v.exp_strobe) begin
        chk({nm, "_stb_cycle"}, stb_k,
            rd ? 1 : 2 + v.waits);
        chk({nm, "_iswrite"}, isw, !rd);
        chk({nm, "_offset"}, off, v.addr[7:2]);
        if (!rd) begin
          chk({nm, "_wval"}, wv, v.exp_val);
          chk({nm, "_be"}, be, v.exp_be);
        end
      end
      exp_x = rd ? ((v.waits > 1) ? 1 + v.waits : 2)
                 : 1 + v.waits;
      chk({nm, "_xfer_cycle"}, xfer_k, exp_x);
      exp_stop = rd && !v.burst && v.waits == 0;
      chk({nm, "_stop"}, stopv, exp_stop);
      chk({nm, "_turn"}, {turn_dev, turn_oe},
          2'b11);
      if (rd) begin
        chk({nm, "_trdy_cycle"}, trdy_k, 2);
        chk({nm, "_rdata"}, rdat, v.exp_val);
        chk({nm, "_stable"}, unstable, 0);
      end
      chk({nm, "_release"},
          {devsel_n, ctl_oe, ad_oe}, 3'b100);
      if (!rd && v.exp_strobe)
        exp_mem[v.addr[7:2]] =
          merge(exp_mem[v.addr[7:2]],
                v.exp_val, v.exp_be);
    end else begin
      chk({nm, "_no_devsel"}, dev_seen, 0);
      chk({nm, "_no_strobe"}, strobes, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    mem[0] = 32'h11E81234;
    exp_mem[0] = 32'h11E81234;
    rst_exp = {15'b0, 32'h0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 6'h0,
               32'h0, 4'h0};

    tbl[0]  = mk(RD, 1, 32'h0, 0, 4'h0, 0, 0,
                 1, 1, 32'h11E81234, 4'h0);
    tnm[0]  = "rd_off0";
    tbl[1]  = mk(WR, 1, 32'h3C, 32'hB, 4'hE, 0, 0,
                 1, 1, 32'hB, 4'h1);
    tnm[1]  = "wr_off0f";
    tbl[2]  = mk(RD, 0, 32'h0, 0, 4'h0, 0, 0,
                 0, 0, 0, 4'h0);
    tnm[2]  = "idsel0";
    tbl[3]  = mk(RD, 1, 32'h1, 0, 4'h0, 0, 0,
                 0, 0, 0, 4'h0);
    tnm[3]  = "type1";
    tbl[4]  = mk(RD, 1, 32'h3C, 0, 4'h0, 0, 1,
                 1, 1, 32'hB, 4'h0);
    tnm[4]  = "burst_rd";
    tbl[5]  = mk(RD, 1, 32'h0, 0, 4'h0, 3, 0,
                 1, 1, 32'h11E81234, 4'h0);
    tnm[5]  = "rd_wait3";
    tbl[6]  = mk(WR, 1, 32'h3C, 32'hFFFFFFFF,
                 4'hF, 1, 0, 1, 0,
                 32'hFFFFFFFF, 4'h0);
    tnm[6]  = "wr_no_bytes";
    tbl[7]  = mk(RD, 1, 32'h3C, 0, 4'h0, 0, 0,
                 1, 1, 32'hB, 4'h0);
    tnm[7]  = "rd_off0f";
    tbl[8]  = mk(WR, 1, 32'h14, 32'hDEADBEEF,
                 4'h0, 2, 0, 1, 1,
                 32'hDEADBEEF, 4'hF);
    tnm[8]  = "wr_wait2";
    tbl[9]  = mk(RD, 1, 32'h14, 0, 4'h0, 1, 1,
                 1, 1, 32'hDEADBEEF, 4'h0);
    tnm[9]  = "burst_rd_wait";
    tbl[10] = mk(4'b0110, 1, 32'h8, 0, 4'h0, 0, 0,
                 0, 0, 0, 4'h0);
    tnm[10] = "mem_rd_cmd";
    tbl[11] = mk(WR, 1, 32'h14, 32'h12345678,
                 4'h5, 0, 0, 1, 1,
                 32'h12345678, 4'hA);
    tnm[11] = "wr_partial";
    tbl[12] = mk(RD, 1, 32'h14, 0, 4'h0, 0, 0,
                 1, 1, 32'h12AD56EF, 4'h0);
    tnm[12] = "rd_merged";

    tick();
    tick();
    chk("reset_values",
        {15'b0, ad_out, ad_oe, devsel_n, trdy_n,
         stop_n, ctl_oe, cfg_enable, cfg_iswrite,
         cfg_offset, cfg_write_val, cfg_byte_en},
        rst_exp);
    rst = 1;
    tick();

    for (int i = 0; i < 13; i++)
      run_txn(tbl[i], tnm[i]);

    // Write whose master goes idle: abort
    ab_str = 0; d16 = 0; d17 = 0;
    frame_n = 0; irdy_n = 1; idsel = 1;
    ad_in = 32'hC; cbe_n = WR;
    tick();
    frame_n = 1; irdy_n = 1; idsel = 0;
    for (int k = 1; k <= 20; k++) begin
      if (cfg_enable) ab_str++;
      if (k == 16) d16 = devsel_n;
      if (k == 17) d17 = devsel_n;
      tick();
    end
    chk("abort_hold", d16, 0);
    chk("abort_turn", d17, 1);
    chk("abort_strobes", ab_str, 0);
    chk("abort_idle", {devsel_n, ctl_oe}, 2'b10);

    // Reset in the middle of a read data phase
    frame_n = 0; irdy_n = 1; idsel = 1;
    ad_in = 32'h8; cbe_n = RD;
    tick();
    idsel = 0;
    tick();
    chk("rst_mid_trdy", trdy_n, 0);
    rst = 0; frame_n = 1; irdy_n = 1;
    tick();
    chk("rst_mid_values",
        {15'b0, ad_out, ad_oe, devsel_n, trdy_n,
         stop_n, ctl_oe, cfg_enable, cfg_iswrite,
         cfg_offset, cfg_write_val, cfg_byte_en},
        rst_exp);
    rst = 1;
    tick();
    run_txn(tbl[0], "rd_after_rst");

    // Random transactions against the model
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [5:0] o;
      kind = $urandom_range(0, 9);
      o = 6'($urandom_range(0, 7));
      rv.sel = 1;
      rv.addr = {24'($urandom), o, 2'b00};
      rv.wdata = $urandom;
      rv.dbe_n = 4'($urandom);
      rv.waits = $urandom_range(0, 3);
      rv.burst = 1'($urandom_range(0, 1));
      rv.exp_be = 4'h0;
      rv.exp_val = 32'h0;
      if (kind == 0) begin
        rv.exp_claim = 0;
        rv.exp_strobe = 0;
        case ($urandom_range(0, 2))
          0: begin rv.cmd = RD; rv.sel = 0; end
          1: begin
            rv.cmd = WR;
            rv.addr[1:0] = 2'b01;
          end
          default: rv.cmd = 4'b0110;
        endcase
      end else if (kind < 5) begin
        rv.cmd = RD;
        rv.exp_claim = 1;
        rv.exp_strobe = 1;
        rv.exp_val = exp_mem[o];
      end else begin
        rv.cmd = WR;
        rv.exp_claim = 1;
        rv.exp_strobe = (rv.dbe_n != 4'hF);
        rv.exp_val = rv.wdata;
        rv.exp_be = ~rv.dbe_n;
      end
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_cfg_target.md
# pci_cfg_target

PCI type-0 configuration-cycle target sequencer. It sits between the PCI bus pin logic (tristates resolved outside) and the configuration register file. It decodes configuration read/write address phases and drives DEVSEL#/TRDY#/STOP#. It issues single-cycle requests on the register file's cfg_enable/cfg_iswrite/cfg_offset/cfg_write_val port and returns read data on AD. Every access is single-data-phase; bursts are terminated with disconnect-with-data.

## Interface
Parameters: none.
- clk  in  1  PCI clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- frame_n  in  1  sampled FRAME#.
- irdy_n  in  1  sampled IRDY#.
- idsel  in  1  IDSEL for this device.
- ad_in  in  32  sampled AD.
- cbe_n  in  4  sampled C/BE#.
- ad_out  out  32  AD drive value.
- ad_oe  out  1  AD output enable.
- devsel_n  out  1  DEVSEL# value.
- trdy_n  out  1  TRDY# value.
- stop_n  out  1  STOP# value.
- ctl_oe  out  1  output enable for DEVSEL#/TRDY#/STOP#.
- cfg_enable  out  1  one-cycle register-file request strobe.
- cfg_iswrite  out  1  request is a write.
- cfg_offset  out  6  dword offset (AD[7:2] of address phase).
- cfg_write_val  out  32  write data.
- cfg_byte_en  out  4  active-high byte enables for a write (~C/BE#).
- cfg_read_val  in  32  register-file read data, valid the cycle after a read strobe.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_COMMIT, TURN.
- IDLE: claim when frame_n=0, idsel=1, ad_in[1:0]=00 and cbe_n is 4'b1010 (read) or 4'b1011 (write). Latch ad_in[7:2] into cfg_offset. Go to RD_REQ or WR_DATA. Otherwise stay idle and never drive.
- Claim is detected only on the first cycle FRAME# is low. While in IDLE, a transaction already in progress (frame_n low on the previous cycle too) is ignored.
- RD_REQ: devsel_n=0, trdy_n=1, stop_n=1, ctl_oe=1, ad_oe=0 (turnaround). Pulse cfg_enable=1, cfg_iswrite=0. Next state RD_DATA.
- RD_DATA, first cycle: capture cfg_read_val into ad_out. ad_oe=1, trdy_n=0. stop_n=0 if frame_n=0, else 1. Hold this state until irdy_n=0, then go to TURN.
- WR_DATA: devsel_n=0, trdy_n=0, ad_oe=0. stop_n=0 while frame_n=0. When irdy_n=0, latch ad_in into cfg_write_val and ~cbe_n into cfg_byte_en, then go to WR_COMMIT.
- WR_COMMIT: pulse cfg_enable=1, cfg_iswrite=1, only if cfg_byte_en≠0; no strobe when all bytes are disabled. devsel_n/trdy_n/stop_n driven high, ctl_oe=1. Next state TURN.
- TURN: ad_oe=0; devsel_n, trdy_n and stop_n all 1; ctl_oe=0. Return to IDLE.
- Read TURN: on entry, devsel_n/trdy_n/stop_n are driven high with ctl_oe=1 for that one cycle. ctl_oe releases the cycle after.
- Master abort mid-transfer (frame_n=1 and irdy_n=1 while in RD_DATA/WR_DATA for 16 consecutive cycles): go to TURN with no cfg_enable strobe.
- Reset (rst=0) in any state: IDLE next edge. All enables deasserted, all PCI controls 1. No strobe issued.

## Timing
- Reset values: ad_out=0, ad_oe=0, devsel_n=1, trdy_n=1, stop_n=1, ctl_oe=0, cfg_enable=0, cfg_iswrite=0, cfg_offset=0, cfg_write_val=0, cfg_byte_en=0.
- Address phase on edge A. Read: DEVSEL# low at A+1, strobe at A+1, data/TRDY# at A+2. Minimum read is 4 cycles, IDLE→IDLE.
- Write: DEVSEL#/TRDY# low at A+1. With IRDY# low at A+1, strobe at A+2. cfg_write_val is stable from the strobe cycle until the next write.
- cfg_enable is never high for two consecutive cycles. cfg_offset is held constant from RD_REQ/WR_DATA until the next claim.
- All outputs are registered.
- Back-to-back claim is permitted in the cycle after TURN.

## Structure
- Shared package pci_pkg holds:
  - the PCI command encodings (CMD_CFG_READ=4'b1010, CMD_CFG_WRITE=4'b1011);
  - the state enum;
  - the master-abort count constant (16).
- Single module, no sub-modules; the abort counter is a 4-bit field inline.

## Test plan
- Read offset 0x00: address 0x00000000, cbe_n=1010, idsel=1. Expect cfg_enable at A+1 with offset 0. Expect ad_out=0x11E81234 with trdy_n=0 at A+2.
- Write offset 0x0F: data 0x0000000B, cbe_n=1110 in the data phase. Expect cfg_enable=1, cfg_iswrite=1, cfg_write_val=0x0000000B, cfg_byte_en=0001 at A+2.
- idsel=0 or ad_in[1:0]=01 (type 1): expect no strobe and devsel_n=1 throughout.
- Burst read (frame_n held low): expect stop_n=0 together with trdy_n=0, and exactly one cfg_enable.
- IRDY# wait states: irdy_n high for 3 cycles during a read. Expect ad_out held stable and TRDY# held low, then TURN one cycle after irdy_n=0.
- rst=0 asserted during RD_DATA: expect all outputs at reset values next edge. A subsequent read completes normally.
